// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong paddle path.
package pong_pkg;

    typedef enum logic {
        DIG = 1'b0,
        ANA = 1'b1
    } chan_state_t;

    localparam logic [7:0] VPOS_CENTER = 8'h80;

    // Magnitude of a two's-complement byte; 9 bits so that |-128| = 128 fits.
    function automatic logic [8:0] abs9(input logic signed [7:0] v);
        logic signed [8:0] w;
        w = v;
        return (w < 0) ? 9'(-w) : 9'(w);
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's paddle: digital saturating ramp, analog follow, and the
// arbiter that hands control between the two sources.
module paddle_channel
    import pong_pkg::*;
#(
    parameter int STEP       = 2,
    parameter int DEADZONE   = 8,
    parameter int HOLD_TICKS = 60
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [7:0] analog_y,
    input  logic       up,
    input  logic       down,
    output logic [7:0] vpos,
    output logic       src_analog
);

    chan_state_t state, state_nxt;
    logic [7:0]  pos_nxt;
    logic [7:0]  hold_cnt, hold_nxt;

    logic        act;
    logic        btn;
    logic [7:0]  target;
    logic [8:0]  pos_dec;
    logic [8:0]  pos_inc;
    logic [8:0]  hold_inc;
    logic [7:0]  pos_ramp;

    assign act    = abs9(analog_y) > 9'(DEADZONE);
    assign btn    = up | down;
    assign target = analog_y + VPOS_CENTER;

    // A borrow out of bit 7 means the step would cross the top edge.
    assign pos_dec  = {1'b0, vpos} - 9'(STEP);
    assign pos_inc  = {1'b0, vpos} + 9'(STEP);
    assign hold_inc = {1'b0, hold_cnt} + 9'd1;

    always_comb begin
        pos_ramp = vpos;
        if (up && !down)
            pos_ramp = pos_dec[8] ? 8'h00 : pos_dec[7:0];
        else if (down && !up)
            pos_ramp = pos_inc[8] ? 8'hFF : pos_inc[7:0];
    end

    // NOTE: every output of this block gets a default up front so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        pos_nxt   = vpos;
        hold_nxt  = hold_cnt;
        case (state)
            DIG: begin
                if (act && !btn) begin
                    state_nxt = ANA;
                    pos_nxt   = target;
                    hold_nxt  = '0;
                end else if (tick) begin
                    pos_nxt = pos_ramp;
                end
            end
            ANA: begin
                if (btn) begin
                    // Hand back to digital; position stays where the stick left it.
                    state_nxt = DIG;
                end else if (act) begin
                    pos_nxt  = target;
                    hold_nxt = '0;
                end else if (tick && hold_inc >= 9'(HOLD_TICKS)) begin
                    state_nxt = DIG;
                    hold_nxt  = '0;
                end else begin
                    pos_nxt = target;
                    if (tick)
                        hold_nxt = hold_inc[7:0];
                end
            end
            default: begin
                state_nxt = DIG;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= DIG;
            vpos     <= VPOS_CENTER;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            vpos     <= pos_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign src_analog = (state == ANA);

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position generator: shared ramp tick divider feeding two
// independent player channels.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV   = 59659,
    parameter int STEP       = 2,
    parameter int DEADZONE   = 8,
    parameter int HOLD_TICKS = 60
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] p1_analog_y,
    input  logic [7:0] p2_analog_y,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [7:0] paddle1_vpos,
    output logic [7:0] paddle2_vpos,
    output logic       p1_src_analog,
    output logic       p2_src_analog,
    output logic       tick
);

    logic [15:0] tick_cnt;
    logic        tick_last;

    assign tick_last = (tick_cnt == 16'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_last ? '0 : tick_cnt + 16'd1;
            tick     <= tick_last;
        end
    end

    paddle_channel #(
        .STEP       (STEP),
        .DEADZONE   (DEADZONE),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_p1 (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tick       (tick),
        .analog_y   (p1_analog_y),
        .up         (p1_up),
        .down       (p1_down),
        .vpos       (paddle1_vpos),
        .src_analog (p1_src_analog)
    );

    paddle_channel #(
        .STEP       (STEP),
        .DEADZONE   (DEADZONE),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_p2 (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tick       (tick),
        .analog_y   (p2_analog_y),
        .up         (p2_up),
        .down       (p2_down),
        .vpos       (paddle2_vpos),
        .src_analog (p2_src_analog)
    );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed steps plus random stimulus
// against a behavioural model of both players and the shared tick.
module tb_paddle_ctrl;

    localparam int TD = 4;
    localparam int ST = 2;
    localparam int DZ = 8;
    localparam int HT = 3;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] p1_analog_y, p2_analog_y;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [7:0] paddle1_vpos, paddle2_vpos;
    logic       p1_src_analog, p2_src_analog;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_ana  [2];
    int m_pos  [2];
    int m_hold [2];
    int m_edges;
    bit m_tick;

    paddle_ctrl #(
        .TICK_DIV   (TD),
        .STEP       (ST),
        .DEADZONE   (DZ),
        .HOLD_TICKS (HT)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .p1_analog_y   (p1_analog_y),
        .p2_analog_y   (p2_analog_y),
        .p1_up         (p1_up),
        .p1_down       (p1_down),
        .p2_up         (p2_up),
        .p2_down       (p2_down),
        .paddle1_vpos  (paddle1_vpos),
        .paddle2_vpos  (paddle2_vpos),
        .p1_src_analog (p1_src_analog),
        .p2_src_analog (p2_src_analog),
        .tick          (tick)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_ana[c]  = 1'b0;
            m_pos[c]  = 128;
            m_hold[c] = 0;
        end
        m_edges = 0;
        m_tick  = 1'b0;
    endtask

    // Player behaviour from the rules: stick active when |Y| > DZ, target is Y+128.
    task automatic model_chan(input int c, input logic [7:0] y, input logic up, input logic dn, input bit tk);
        int  sy, mag, tgt;
        bit  act, btn;
        sy  = int'($signed(y));
        mag = (sy < 0) ? -sy : sy;
        act = (mag > DZ);
        tgt = (sy + 128) % 256;
        btn = up || dn;
        if (!m_ana[c]) begin
            if (act && !btn) begin
                m_ana[c]  = 1'b1;
                m_pos[c]  = tgt;
                m_hold[c] = 0;
            end else if (tk) begin
                if (up && !dn)
                    m_pos[c] = (m_pos[c] - ST < 0) ? 0 : m_pos[c] - ST;
                else if (dn && !up)
                    m_pos[c] = (m_pos[c] + ST > 255) ? 255 : m_pos[c] + ST;
            end
        end else begin
            if (btn) begin
                m_ana[c] = 1'b0;
            end else if (act) begin
                m_pos[c]  = tgt;
                m_hold[c] = 0;
            end else if (tk) begin
                m_hold[c]++;
                if (m_hold[c] >= HT)
                    m_ana[c] = 1'b0;
                else
                    m_pos[c] = tgt;
            end else begin
                m_pos[c] = tgt;
            end
        end
    endtask

    task automatic step();
        model_chan(0, p1_analog_y, p1_up, p1_down, m_tick);
        model_chan(1, p2_analog_y, p2_up, p2_down, m_tick);
        m_edges++;
        m_tick = (m_edges % TD == 0);
        @(posedge clk_sys);
        #1;
        check("vpos1", 16'(paddle1_vpos), 16'(m_pos[0]));
        check("vpos2", 16'(paddle2_vpos), 16'(m_pos[1]));
        check("src1",  16'(p1_src_analog), 16'(m_ana[0]));
        check("src2",  16'(p2_src_analog), 16'(m_ana[1]));
        check("tick",  16'(tick), 16'(m_tick));
    endtask

    task automatic idle_inputs();
        p1_analog_y = 8'h00;
        p2_analog_y = 8'h00;
        p1_up       = 1'b0;
        p1_down     = 1'b0;
        p2_up       = 1'b0;
        p2_down     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_vpos1", 16'(paddle1_vpos), 16'h80);
        check("rst_vpos2", 16'(paddle2_vpos), 16'h80);
        check("rst_src1",  16'(p1_src_analog), 16'h0);
        check("rst_src2",  16'(p2_src_analog), 16'h0);
        check("rst_tick",  16'(tick), 16'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Tick cadence: first high at cycle TD, then every TD cycles.
        for (int i = 1; i <= 12; i++) begin
            step();
            check("tick_cadence", 16'(tick), 16'((i % TD) == 0));
        end

        // Up held for 70 ticks: ramps down to the top edge and stays there.
        p1_up = 1'b1;
        repeat (70 * TD) step();
        check("p1_floor", 16'(paddle1_vpos), 16'h00);
        check("p2_untouched", 16'(paddle2_vpos), 16'h80);

        // Down held long enough to saturate at the bottom edge.
        p1_up   = 1'b0;
        p1_down = 1'b1;
        repeat (130 * TD) step();
        check("p1_ceiling", 16'(paddle1_vpos), 16'hFF);

        // Analog takeover just outside the deadzone.
        p1_down = 1'b0;
        step();
        p1_analog_y = 8'h09;
        step();
        check("ana_enter_src", 16'(p1_src_analog), 16'h1);
        check("ana_enter_pos", 16'(paddle1_vpos), 16'h89);
        p1_analog_y = 8'h80;
        step();
        check("ana_min_y", 16'(paddle1_vpos), 16'h00);

        // Back to digital; deadzone edges must not re-enter analog.
        p1_up = 1'b1;
        step();
        check("btn_exit", 16'(p1_src_analog), 16'h0);
        p1_up = 1'b0;
        p1_analog_y = 8'h08;
        repeat (10) step();
        check("dz_pos_edge", 16'(p1_src_analog), 16'h0);
        p1_analog_y = 8'hF8;
        repeat (3) step();
        check("dz_neg_edge", 16'(p1_src_analog), 16'h0);
        p1_analog_y = 8'hF7;
        step();
        check("neg_enter_pos", 16'(paddle1_vpos), 16'h77);

        // Inactivity timeout reverts after HT ticks with position kept.
        p1_analog_y = 8'h00;
        repeat ((HT + 2) * TD) step();
        check("hold_timeout_src", 16'(p1_src_analog), 16'h0);
        check("hold_timeout_pos", 16'(paddle1_vpos), 16'h80);

        // Re-activation before timeout clears the hold count.
        p1_analog_y = 8'h20;
        step();
        p1_analog_y = 8'h00;
        repeat (2 * TD) step();
        p1_analog_y = 8'h20;
        step();
        p1_analog_y = 8'h00;
        repeat (2 * TD) step();
        check("hold_rearm_src", 16'(p1_src_analog), 16'h1);

        // Button beats stick in ANA; stick stays locked out while held.
        p1_analog_y = 8'h40;
        step();
        check("ana_c0", 16'(paddle1_vpos), 16'hC0);
        p1_down = 1'b1;
        step();
        check("btn_wins_src", 16'(p1_src_analog), 16'h0);
        repeat (3 * TD) step();
        check("btn_lockout", 16'(p1_src_analog), 16'h0);
        p1_down = 1'b0;
        idle_inputs();
        step();

        // Random mix of stick and button activity on both players.
        repeat (3000) begin
            p1_analog_y = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 24) - 12) : 8'($urandom);
            p2_analog_y = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 24) - 12) : 8'($urandom);
            if ($urandom_range(0, 39) == 0) p1_up   = ~p1_up;
            if ($urandom_range(0, 39) == 0) p1_down = ~p1_down;
            if ($urandom_range(0, 39) == 0) p2_up   = ~p2_up;
            if ($urandom_range(0, 39) == 0) p2_down = ~p2_down;
            if ($urandom_range(0, 7) == 0) p1_analog_y = 8'h00;
            step();
        end

        // Asynchronous reset between edges, mid-ramp.
        idle_inputs();
        p1_up = 1'b1;
        repeat (13) step();
        #3;
        reset_n = 1'b0;
        #1;
        check("async_vpos1", 16'(paddle1_vpos), 16'h80);
        check("async_src1",  16'(p1_src_analog), 16'h0);
        check("async_tick",  16'(tick), 16'h0);
        idle_inputs();
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 9; i++) begin
            step();
            check("tick_restart", 16'(tick), 16'((i % TD) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Produces the two 8-bit paddle vertical positions for the Pong core, replacing the direct stick-plus-0x80 mapping.
- Each player's position is shared between two sources: the analog stick Y axis and digital up/down (joystick or keyboard). An arbiter picks the active source per player.
- Digital control integrates a saturating position counter at a fixed tick rate.
- Sits between the input decode and the pong core, all in clk_sys (7.159 MHz).

Parameters:
- TICK_DIV, 59659: clk_sys cycles per ramp tick (~120 Hz); legal range 2..65535.
- STEP, 2: position change per tick under digital control; legal range 1..64.
- DEADZONE, 8: analog counts of |Y| at or below which the stick is inactive; legal range 0..127.
- HOLD_TICKS, 60: ticks of continuous analog inactivity before reverting to digital; legal range 1..255.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p1_analog_y  in  8  player 1 stick Y, two's complement
- p2_analog_y  in  8  player 2 stick Y, two's complement
- p1_up  in  1  player 1 digital up (level)
- p1_down  in  1  player 1 digital down (level)
- p2_up  in  1  player 2 digital up (level)
- p2_down  in  1  player 2 digital down (level)
- paddle1_vpos  out  8  player 1 position, 0 = top
- paddle2_vpos  out  8  player 2 position, 0 = top
- p1_src_analog  out  1  1 when player 1 is under analog control
- p2_src_analog  out  1  1 when player 2 is under analog control
- tick  out  1  single-cycle ramp tick strobe

Behaviour:
- Reset (async assert, sync release on clk_sys):
  - vpos outputs = 0x80, src_analog = 0, tick = 0, tick counter = 0.
  - Both channels in state DIG; hold counters = 0.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and is high for exactly one cycle, in the cycle after the counter equals TICK_DIV-1.
  - First tick after reset is at cycle TICK_DIV.
  - One tick is shared by both channels.
- Analog activity: act = |Y| > DEADZONE, with |-128| = 128 computed in 9 bits. Target position = Y + 0x80, modulo 256.
- Channel FSM, states DIG and ANA, evaluated every clk_sys edge:
  - DIG, on tick:
    - up=1, down=0: pos = max(pos-STEP, 0).
    - down=1, up=0: pos = min(pos+STEP, 255).
    - both or neither: hold.
    - Saturation uses 9-bit intermediate arithmetic; no wrap-around.
  - DIG -> ANA when act=1 and up=0 and down=0. Same cycle: pos loads target; hold counter clears.
  - ANA: pos = target every cycle (1-cycle latency from Y to vpos).
  - ANA hold counter:
    - act=1 clears it.
    - On tick with act=0 it increments.
    - Reaching HOLD_TICKS -> DIG; pos retains its last value.
  - ANA -> DIG immediately when up or down is 1. pos is retained and the ramp continues from it at the next tick.
  - Simultaneous button and act:
    - In ANA, the button wins (go to DIG).
    - In DIG, analog entry is blocked while any button is held.
  - A DIG->ANA or ANA->DIG transition coinciding with a tick: the transition takes priority and no ramp step is applied that cycle.
- src_analog is registered and equals (state == ANA).
- Player channels are fully independent; only tick is shared.
- Reset asserted mid-ramp or in ANA returns to reset values immediately, without waiting for a clock.

Decomposition:
- Shared package pong_pkg holds:
  - the channel state enum {DIG, ANA};
  - the constant VPOS_CENTER = 8'h80;
  - a function abs9(signed [7:0]) returning [8:0].
- One sub-module paddle_channel (FSM, saturating ramp, hold counter), instantiated twice.
- The tick divider lives in paddle_ctrl.

Test Plan:
- Reset with TICK_DIV=4 -> vpos=0x80, src=0; tick first high at cycle 4, then every 4 cycles.
- TICK_DIV=4, STEP=2, p1_up held for 70 ticks -> paddle1_vpos 0x80,0x7E,...,0x00 after 64 ticks, stays 0x00; paddle2 unchanged.
- Buttons released, p1_analog_y=0x09 with DEADZONE=8 -> next cycle src=1, vpos=0x89. Y=0x08 while in DIG -> no switch. Y=0x80 -> vpos=0x00.
- In ANA, Y=0x00 for HOLD_TICKS=3 ticks -> src drops after 3rd tick, vpos holds last value. Re-activate at tick 2 -> counter clears, src stays 1.
- In ANA with Y=0x40 (vpos=0xC0), assert p1_down -> src=0 next cycle; following ticks give 0xC2,0xC4. With p1_down still held, Y stays 0x40 -> remains DIG.
- Assert reset_n=0 mid-ramp between clock edges -> outputs 0x80/0 immediately. Release -> tick counter restarts from 0.
